// File: rtl/stack_pkg.sv
// Opcode encoding and legality helpers shared by the operand stack and the instruction decoder.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_DUP     = 3'd4,
    OP_SWAP    = 3'd5,
    OP_OVER    = 3'd6,
    OP_CLEAR   = 3'd7
  } stack_op_e;

  // Minimum number of valid entries the op reads before it may execute.
  function automatic logic [1:0] needs_operands(input stack_op_e op);
    logic [1:0] n;
    n = 2'd0;
    case (op)
      OP_POP, OP_REPLACE, OP_DUP: n = 2'd1;
      OP_SWAP, OP_OVER:           n = 2'd2;
      default:                    n = 2'd0;
    endcase
    return n;
  endfunction

  // True when the op grows the stack and therefore needs a free slot.
  function automatic logic needs_slot(input stack_op_e op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Parametrised LIFO operand stack: one op per clock, top two entries exposed combinationally.
// Rejected ops leave state untouched, pulse err for one cycle and set a sticky ovf/unf flag.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  stack_op_e        op_e;
  logic [AW-1:0]    wr_idx, top_idx, nos_idx;
  logic [WIDTH-1:0] top_raw, nos_raw;
  logic             unf_hit, ovf_hit;

  assign op_e    = stack_op_e'(op);
  assign wr_idx  = AW'(count_q);
  assign top_idx = AW'(count_q - CW'(1));
  assign nos_idx = AW'(count_q - CW'(2));
  assign top_raw = mem_q[top_idx];
  assign nos_raw = mem_q[nos_idx];

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Stale memory below the fill level must never leak to the ALU.
  assign tos   = empty ? '0 : top_raw;
  assign nos   = (count_q < CW'(2)) ? '0 : nos_raw;
  assign count = count_q;
  assign err   = err_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

  // Underflow is checked first so a short stack never reports overflow.
  assign unf_hit = (count_q < CW'(needs_operands(op_e)));
  assign ovf_hit = !unf_hit && needs_slot(op_e) && full;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    err_d   = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (unf_hit) begin
      err_d = 1'b1;
      unf_d = 1'b1;
    end else if (ovf_hit) begin
      err_d = 1'b1;
      ovf_d = 1'b1;
    end else begin
      case (op_e)
        OP_PUSH: begin
          mem_d[wr_idx] = data_in;
          count_d       = count_q + CW'(1);
        end
        OP_POP: count_d = count_q - CW'(1);
        OP_REPLACE: mem_d[top_idx] = data_in;
        OP_DUP: begin
          mem_d[wr_idx] = top_raw;
          count_d       = count_q + CW'(1);
        end
        OP_SWAP: begin
          mem_d[top_idx] = nos_raw;
          mem_d[nos_idx] = top_raw;
        end
        OP_OVER: begin
          mem_d[wr_idx] = nos_raw;
          count_d       = count_q + CW'(1);
        end
        OP_CLEAR: begin
          count_d = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage carries no reset; count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed and queue-model checks of stack_ctrl at WIDTH=16, DEPTH=4.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, err, ovf, unf;

  int n_checks = 0;
  int n_errors = 0;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .data_in(data_in),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .err(err), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge; applies op for the next edge and returns 1 time unit after it.
  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d);
    op      = o;
    data_in = d;
    @(posedge clk);
    #1;
    op      = OP_NOP;
    data_in = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full),  0);
    chk({tag, "_tos"},   32'(tos),   0);
    chk({tag, "_nos"},   32'(nos),   0);
    chk({tag, "_err"},   32'(err),   0);
    chk({tag, "_ovf"},   32'(ovf),   0);
    chk({tag, "_unf"},   32'(unf),   0);
  endtask

  logic [WIDTH-1:0] q[$];
  logic             m_err, m_ovf, m_unf;

  initial begin
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full, then overflow.
    step(OP_PUSH, 16'h1111);
    step(OP_PUSH, 16'h2222);
    step(OP_PUSH, 16'h3333);
    step(OP_PUSH, 16'h4444);
    chk("fill_count", 32'(count), 4);
    chk("fill_full",  32'(full),  1);
    chk("fill_tos",   32'(tos),   32'h4444);
    chk("fill_nos",   32'(nos),   32'h3333);
    step(OP_PUSH, 16'h5555);
    chk("ovf_err",   32'(err),   1);
    chk("ovf_flag",  32'(ovf),   1);
    chk("ovf_unf",   32'(unf),   0);
    chk("ovf_tos",   32'(tos),   32'h4444);
    chk("ovf_count", 32'(count), 4);
    step(OP_NOP, '0);
    chk("err_drop",   32'(err), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    step(OP_CLEAR, '0);
    chk("clr1_count", 32'(count), 0);
    chk("clr1_ovf",   32'(ovf),   0);

    // SWAP / OVER / DUP from [1111, 2222].
    step(OP_PUSH, 16'h1111);
    step(OP_PUSH, 16'h2222);
    step(OP_SWAP, '0);
    chk("swap_tos", 32'(tos), 32'h1111);
    chk("swap_nos", 32'(nos), 32'h2222);
    chk("swap_err", 32'(err), 0);
    step(OP_OVER, '0);
    chk("over_count", 32'(count), 3);
    chk("over_tos",   32'(tos),   32'h2222);
    chk("over_nos",   32'(nos),   32'h1111);
    step(OP_DUP, '0);
    chk("dup_count", 32'(count), 4);
    chk("dup_tos",   32'(tos),   32'h2222);
    chk("dup_nos",   32'(nos),   32'h2222);
    step(OP_OVER, '0);
    chk("over_full_err", 32'(err), 1);
    chk("over_full_ovf", 32'(ovf), 1);
    chk("over_full_unf", 32'(unf), 0);
    chk("over_full_cnt", 32'(count), 4);

    // Drain, then REPLACE and underflow with ovf already set.
    for (int i = 0; i < 4; i++) step(OP_POP, '0);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_err",   32'(err),   0);
    step(OP_PUSH, 16'h1111);
    step(OP_SWAP, '0);
    chk("swap1_err",   32'(err),   1);
    chk("swap1_unf",   32'(unf),   1);
    chk("swap1_tos",   32'(tos),   32'h1111);
    chk("swap1_nos",   32'(nos),   0);
    step(OP_PUSH, 16'h2222);
    step(OP_REPLACE, 16'hBEEF);
    chk("repl_count", 32'(count), 2);
    chk("repl_tos",   32'(tos),   32'hBEEF);
    chk("repl_nos",   32'(nos),   32'h1111);
    step(OP_POP, '0);
    step(OP_POP, '0);
    chk("pop2_empty", 32'(empty), 1);
    chk("pop2_tos",   32'(tos),   0);
    step(OP_POP, '0);
    chk("unf_err",   32'(err),   1);
    chk("unf_flag",  32'(unf),   1);
    chk("unf_ovf",   32'(ovf),   1);
    chk("unf_count", 32'(count), 0);

    // CLEAR wipes both sticky flags.
    step(OP_CLEAR, '0);
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf",   32'(ovf),   0);
    chk("clr_unf",   32'(unf),   0);
    chk("clr_err",   32'(err),   0);
    step(OP_PUSH, 16'h00AA);
    chk("aa_tos",   32'(tos),   32'h00AA);
    chk("aa_count", 32'(count), 1);

    // Asynchronous reset mid-cycle at count=3.
    step(OP_PUSH, 16'h0BB0);
    step(OP_PUSH, 16'h0CC0);
    chk("pre_rst_count", 32'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("arst");
    #1;
    rst_n = 1'b1;
    step(OP_PUSH, 16'h1234);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_tos",   32'(tos),   32'h1234);

    // Random op stream against a queue model.
    q.delete();
    q.push_back(16'h1234);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0]       r_op;
      logic [WIDTH-1:0] r_dat;
      int               sz;
      r_op  = 3'($urandom_range(0, 7));
      r_dat = WIDTH'($urandom);
      if (r_op == 3'd7 && $urandom_range(0, 7) != 0) r_op = 3'd1;
      sz    = q.size();
      m_err = 1'b0;
      case (r_op)
        3'd1: if (sz == DEPTH) begin m_err = 1; m_ovf = 1; end
              else q.push_back(r_dat);
        3'd2: if (sz < 1) begin m_err = 1; m_unf = 1; end
              else void'(q.pop_back());
        3'd3: if (sz < 1) begin m_err = 1; m_unf = 1; end
              else q[sz-1] = r_dat;
        3'd4: if (sz < 1) begin m_err = 1; m_unf = 1; end
              else if (sz == DEPTH) begin m_err = 1; m_ovf = 1; end
              else q.push_back(q[sz-1]);
        3'd5: if (sz < 2) begin m_err = 1; m_unf = 1; end
              else begin
                logic [WIDTH-1:0] t;
                t = q[sz-1]; q[sz-1] = q[sz-2]; q[sz-2] = t;
              end
        3'd6: if (sz < 2) begin m_err = 1; m_unf = 1; end
              else if (sz == DEPTH) begin m_err = 1; m_ovf = 1; end
              else q.push_back(q[sz-2]);
        3'd7: begin q.delete(); m_ovf = 0; m_unf = 0; end
        default: ;
      endcase
      step(r_op, r_dat);
      sz = q.size();
      chk("rnd_count", 32'(count), 32'(sz));
      chk("rnd_tos",   32'(tos),   (sz > 0) ? 32'(q[sz-1]) : 32'd0);
      chk("rnd_nos",   32'(nos),   (sz > 1) ? 32'(q[sz-2]) : 32'd0);
      chk("rnd_err",   32'(err),   32'(m_err));
      chk("rnd_ovf",   32'(ovf),   32'(m_ovf));
      chk("rnd_unf",   32'(unf),   32'(m_unf));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
